// File: rtl/buffer_filler_pkg.sv
// Shared types and constants for the buffer write-side producer.
package buffer_filler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PAD  = 2'd2,
    DONE = 2'd3
  } fill_state_t;

  // Value written for pad words; sliced down to the buffer word width.
  localparam logic [63:0] FILL_PAD_WORD = '0;

endpackage

// File: rtl/buffer_wr_skid.sv
// Two-entry skid FIFO between the loader stream and the buffer write port.
// Only instantiated when BUF_FILLER_SKID_EN is defined.
module buffer_wr_skid #(
  parameter int DWIDTH = 16
) (
  input  logic              wr_clk,
  input  logic              rstn,
  input  logic              push,
  input  logic [DWIDTH-1:0] din,
  input  logic              pop,
  output logic [DWIDTH-1:0] dout,
  output logic              empty,
  output logic              free
);

  logic [1:0][DWIDTH-1:0] mem;
  logic                   rd_ptr;
  logic                   wr_ptr;
  logic [1:0]             count;

  assign dout  = mem[rd_ptr];
  assign empty = (count == 2'd0);
  assign free  = (count != 2'd2);

  // Pointer/occupancy update; callers never push when full or pop when empty.
  always_ff @(posedge wr_clk) begin
    if (!rstn) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/buffer_filler.sv
// Write-side producer: moves exactly TILE_LEN words per tile into the buffer,
// zero-padding tiles that end early and flagging tiles that never saw in_last.
// Optional macro BUF_FILLER_SKID_EN inserts a 2-entry skid stage (one extra
// cycle of latency, in_ready decoupled from buf_full).
module buffer_filler
  import buffer_filler_pkg::*;
#(
  parameter  int DWIDTH   = 16,
  parameter  int TILE_LEN = 8,
  localparam int CNT_W    = $clog2(TILE_LEN + 1)
) (
  input  logic              wr_clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              buf_full,
  output logic              buf_wr_en,
  output logic [DWIDTH-1:0] buf_din,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  word_count,
  output logic              err_nolast
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TILE_LEN - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TILE_LEN);

  fill_state_t       state;
  logic              fill_wr;
  logic [DWIDTH-1:0] fill_data;
  logic              pad_wr;

`ifdef BUF_FILLER_SKID_EN
  logic              sk_push;
  logic              sk_empty;
  logic              sk_free;
  logic [DWIDTH-1:0] sk_dout;
  logic              stream_end;
  logic [CNT_W-1:0]  acc_count;

  assign in_ready  = rstn && (state == FILL) && !stream_end && sk_free;
  assign sk_push   = in_valid && in_ready;
  assign fill_wr   = rstn && (state == FILL) && !sk_empty && !buf_full;
  assign fill_data = sk_dout;

  buffer_wr_skid #(.DWIDTH(DWIDTH)) u_skid (
    .wr_clk (wr_clk),
    .rstn   (rstn),
    .push   (sk_push),
    .din    (in_data),
    .pop    (fill_wr),
    .dout   (sk_dout),
    .empty  (sk_empty),
    .free   (sk_free)
  );
`else
  assign in_ready  = rstn && (state == FILL) && !buf_full;
  assign fill_wr   = in_valid && in_ready;
  assign fill_data = in_data;
`endif

  assign pad_wr     = rstn && (state == PAD) && !buf_full;
  assign buf_wr_en  = fill_wr || pad_wr;
  assign buf_din    = (state == PAD) ? FILL_PAD_WORD[DWIDTH-1:0] : fill_data;
  assign busy       = (state == FILL) || (state == PAD);
  assign done       = (state == DONE);

  // Tile sequencing, write counter and missing-last flag.
  always_ff @(posedge wr_clk) begin
    if (!rstn) begin
      state      <= IDLE;
      word_count <= '0;
      err_nolast <= 1'b0;
`ifdef BUF_FILLER_SKID_EN
      stream_end <= 1'b0;
      acc_count  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= FILL;
            word_count <= '0;
            err_nolast <= 1'b0;
`ifdef BUF_FILLER_SKID_EN
            stream_end <= 1'b0;
            acc_count  <= '0;
`endif
          end
        end
        FILL: begin
`ifdef BUF_FILLER_SKID_EN
          // Stream side closes on the final word or an early in_last; the
          // state only advances once every accepted word has reached the buffer.
          if (fill_wr) word_count <= word_count + 1'b1;
          if (sk_push) begin
            acc_count <= acc_count + 1'b1;
            if (acc_count == LAST_IDX) begin
              stream_end <= 1'b1;
              err_nolast <= err_nolast | ~in_last;
            end else if (in_last) begin
              stream_end <= 1'b1;
            end
          end
          if (stream_end && sk_empty)
            state <= (word_count == FULL_CNT) ? DONE : PAD;
`else
          if (fill_wr) begin
            word_count <= word_count + 1'b1;
            if (word_count == LAST_IDX) begin
              state      <= DONE;
              err_nolast <= err_nolast | ~in_last;
            end else if (in_last) begin
              state <= PAD;
            end
          end
`endif
        end
        PAD: begin
          if (pad_wr) begin
            word_count <= word_count + 1'b1;
            if (word_count == LAST_IDX) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_filler.sv
// Directed self-checking bench for buffer_filler (default build, TILE_LEN=8).
module tb_buffer_filler;

  logic        wr_clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic        buf_full;
  logic        buf_wr_en;
  logic [15:0] buf_din;
  logic        busy;
  logic        done;
  logic [3:0]  word_count;
  logic        err_nolast;

  int errors = 0;
  int checks = 0;
  logic [15:0] wq[$];

  always #5 wr_clk = ~wr_clk;

  buffer_filler #(.DWIDTH(16), .TILE_LEN(8)) dut (
    .wr_clk     (wr_clk),
    .rstn       (rstn),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .buf_full   (buf_full),
    .buf_wr_en  (buf_wr_en),
    .buf_din    (buf_din),
    .busy       (busy),
    .done       (done),
    .word_count (word_count),
    .err_nolast (err_nolast)
  );

  // Record every buffer write, sampled mid-cycle.
  always @(negedge wr_clk) if (buf_wr_en === 1'b1) wq.push_back(buf_din);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one word with buf_full low; it must be written this cycle.
  task automatic send(input logic [15:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge wr_clk);
    chk("wr_en", {31'b0, buf_wr_en}, 1);
    chk("din", {16'b0, buf_din}, {16'b0, d});
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_seq(input string tag, input logic [15:0] base);
    chk({tag, "_len"}, wq.size(), 8);
    for (int i = 0; i < 8 && i < wq.size(); i++)
      chk(tag, {16'b0, wq[i]}, {16'b0, base + 16'(i)});
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; buf_full = 1'b0;
    tick(); tick();
    // Reset state
    chk("rst_cnt", {28'b0, word_count}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_err", {31'b0, err_nolast}, 0);
    chk("rst_rdy", {31'b0, in_ready}, 0);
    chk("rst_wr", {31'b0, buf_wr_en}, 0);
    rstn = 1'b1;
    // Idle ignores in_valid
    in_valid = 1'b1; in_data = 16'hdead;
    @(negedge wr_clk);
    chk("idle_rdy", {31'b0, in_ready}, 0);
    chk("idle_wr", {31'b0, buf_wr_en}, 0);
    tick(); in_valid = 1'b0;

    // Full tile with in_last on word 8
    wq.delete();
    do_start();
    chk("t1_busy", {31'b0, busy}, 1);
    for (int i = 0; i < 8; i++) send(16'h11 + 16'(i), i == 7);
    chk("t1_done", {31'b0, done}, 1);
    chk("t1_cnt", {28'b0, word_count}, 8);
    chk("t1_err", {31'b0, err_nolast}, 0);
    tick();
    chk("t1_done_low", {31'b0, done}, 0);
    chk("t1_cnt_hold", {28'b0, word_count}, 8);
    chk_seq("t1_seq", 16'h11);

    // Short tile padded with zeros
    wq.delete();
    do_start();
    for (int i = 0; i < 3; i++) send(16'ha1 + 16'(i), i == 2);
    chk("t2_rdy_pad", {31'b0, in_ready}, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge wr_clk);
      chk("t2_pad_wr", {31'b0, buf_wr_en}, 1);
      chk("t2_pad_din", {16'b0, buf_din}, 0);
      tick();
    end
    chk("t2_done", {31'b0, done}, 1);
    chk("t2_cnt", {28'b0, word_count}, 8);
    chk("t2_len", wq.size(), 8);
    for (int i = 0; i < 8 && i < wq.size(); i++)
      chk("t2_seq", {16'b0, wq[i]}, (i < 3) ? 32'ha1 + i : 32'h0);
    tick();

    // Back-pressure from buf_full after word 2
    wq.delete();
    do_start();
    send(16'h21, 1'b0);
    send(16'h22, 1'b0);
    buf_full = 1'b1; in_valid = 1'b1; in_data = 16'h23;
    for (int i = 0; i < 4; i++) begin
      @(negedge wr_clk);
      chk("t3_full_rdy", {31'b0, in_ready}, 0);
      chk("t3_full_wr", {31'b0, buf_wr_en}, 0);
      chk("t3_full_cnt", {28'b0, word_count}, 2);
      tick();
    end
    buf_full = 1'b0;
    for (int i = 2; i < 8; i++) send(16'h21 + 16'(i), i == 7);
    chk("t3_done", {31'b0, done}, 1);
    chk_seq("t3_seq", 16'h21);
    tick();

    // No in_last anywhere: sticky error until next start
    wq.delete();
    do_start();
    for (int i = 0; i < 8; i++) send(16'h31 + 16'(i), 1'b0);
    chk("t4_done", {31'b0, done}, 1);
    chk("t4_err", {31'b0, err_nolast}, 1);
    tick();
    chk("t4_err_hold", {31'b0, err_nolast}, 1);
    do_start();
    chk("t4_err_clr", {31'b0, err_nolast}, 0);

    // Reset mid-tile after word 4
    wq.delete();
    for (int i = 0; i < 4; i++) send(16'h41 + 16'(i), 1'b0);
    rstn = 1'b0; in_valid = 1'b1; in_data = 16'h45;
    @(negedge wr_clk);
    chk("t5_rst_wr", {31'b0, buf_wr_en}, 0);
    chk("t5_rst_rdy", {31'b0, in_ready}, 0);
    tick();
    rstn = 1'b1; in_valid = 1'b0;
    chk("t5_cnt", {28'b0, word_count}, 0);
    chk("t5_busy", {31'b0, busy}, 0);
    chk("t5_len", wq.size(), 4);

    // Fresh tile, with a stray start pulse during word 3
    wq.delete();
    do_start();
    send(16'h51, 1'b0);
    send(16'h52, 1'b0);
    start = 1'b1;
    send(16'h53, 1'b0);
    start = 1'b0;
    chk("t6_cnt3", {28'b0, word_count}, 3);
    chk("t6_busy", {31'b0, busy}, 1);
    for (int i = 3; i < 8; i++) send(16'h51 + 16'(i), i == 7);
    chk("t6_done", {31'b0, done}, 1);
    chk("t6_cnt", {28'b0, word_count}, 8);
    chk_seq("t6_seq", 16'h51);
    tick();
    chk("t6_idle", {31'b0, busy | done}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
